// File: rtl/calc_display_pkg.sv
// Shared digit codes, FSM state type and parameter sanity helper for the
// calculator display pre-formatter.
package calc_display_pkg;

    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_MINUS = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2,
        ERR     = 2'd3
    } state_t;

    // True when bcd_digits decimal digits can hold every data_w-bit magnitude.
    function automatic bit bcd_covers(input int data_w, input int bcd_digits);
        longint unsigned dec_range;
        longint unsigned bin_range;
        dec_range = 1;
        bin_range = 1;
        for (int i = 0; i < bcd_digits; i++) dec_range = dec_range * 10;
        for (int i = 0; i < data_w; i++) bin_range = bin_range * 2;
        return dec_range >= bin_range;
    endfunction

endpackage

// File: rtl/calc_display_fmt_bin2bcd.sv
// Iterative double-dabble converter: the first shift happens on load, the
// remaining DATA_W-1 shifts follow one per cycle; done pulses with the last one.
module bin2bcd_seq #(
    parameter int DATA_W     = 25,
    parameter int BCD_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [DATA_W-1:0]       data,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CW    = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shift_reg;
    logic [CW-1:0]     cnt_reg;
    logic [BCD_W-1:0]  adj;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        assign adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? bcd[4*gi +: 4] + 4'd3
                                                          : bcd[4*gi +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
            bcd       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                bcd       <= BCD_W'(data[DATA_W-1]);
                shift_reg <= data << 1;
                cnt_reg   <= CW'(DATA_W - 1);
                done      <= (DATA_W == 1);
            end else if (cnt_reg != '0) begin
                bcd       <= BCD_W'({adj, shift_reg[DATA_W-1]});
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg - 1'b1;
                done      <= (cnt_reg == CW'(1));
            end
        end
    end

endmodule

// File: rtl/calc_display_fmt.sv
// Display pre-formatter: converts a scaled fixed-point magnitude to BCD and
// right-justifies integer and significant fractional digits into digit codes.
module calc_display_fmt
    import calc_display_pkg::*;
#(
    parameter int DATA_W      = 25,
    parameter int N_DIGITS    = 4,
    parameter int FRAC_DIGITS = 3,
    parameter int BCD_DIGITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data,
    input  logic                  neg,
    input  logic                  frac,
    input  logic                  error,
    output logic                  out_valid,
    output logic                  out_neg,
    output logic                  out_frac,
    output logic                  overflow,
    output logic [N_DIGITS-1:0]   dp_position,
    output logic [4*N_DIGITS-1:0] disp_num
);

    if (N_DIGITS < 2 || FRAC_DIGITS >= BCD_DIGITS || !bcd_covers(DATA_W, BCD_DIGITS)) begin : g_bad_params
        $error("calc_display_fmt: inconsistent DATA_W/N_DIGITS/FRAC_DIGITS/BCD_DIGITS");
    end

    state_t                  state;
    logic                    neg_reg;
    logic                    frac_reg;
    logic                    load;
    logic                    conv_done;
    logic [4*BCD_DIGITS-1:0] bcd;

    assign in_ready = (state == IDLE);
    assign load     = in_ready && in_valid && !error;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .done  (conv_done),
        .bcd   (bcd)
    );

    int                    int_len;
    int                    frac_len;
    int                    slots;
    int                    shown;
    logic                  ovf_next;
    logic                  frac_next;
    logic [N_DIGITS-1:0]   dp_next;
    logic [4*N_DIGITS-1:0] disp_next;

    always_comb begin
        int_len  = 1;
        frac_len = 0;
        for (int k = FRAC_DIGITS; k < BCD_DIGITS; k++)
            if (bcd[4*k +: 4] != 4'd0) int_len = k - FRAC_DIGITS + 1;
        // Descending scan: the last hit is the lowest non-zero fractional digit.
        for (int k = FRAC_DIGITS - 1; k >= 0; k--)
            if (bcd[4*k +: 4] != 4'd0) frac_len = FRAC_DIGITS - k;
        slots     = N_DIGITS - (neg_reg ? 1 : 0);
        ovf_next  = (int_len > slots);
        shown     = (frac_len < slots - int_len) ? frac_len : slots - int_len;
        frac_next = (frac_len > 0) || frac_reg;
        dp_next   = '0;
        disp_next = '0;
        for (int j = 0; j < N_DIGITS; j++) begin
            disp_next[4*j +: 4] = DIG_BLANK;
            if (j < int_len + shown && FRAC_DIGITS - shown + j >= 0
                    && FRAC_DIGITS - shown + j < BCD_DIGITS)
                disp_next[4*j +: 4] = bcd[4*(FRAC_DIGITS - shown + j) +: 4];
        end
        if (neg_reg) disp_next[4*N_DIGITS-4 +: 4] = DIG_MINUS;
        if (frac_next && !ovf_next) dp_next = N_DIGITS'(1) << shown;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            neg_reg     <= 1'b0;
            frac_reg    <= 1'b0;
            out_valid   <= 1'b0;
            out_neg     <= 1'b0;
            out_frac    <= 1'b0;
            overflow    <= 1'b0;
            dp_position <= '0;
            disp_num    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg_reg  <= neg;
                        frac_reg <= frac;
                        state    <= error ? ERR : CONVERT;
                    end
                end
                CONVERT: if (conv_done) state <= FORMAT;
                FORMAT: begin
                    out_valid   <= 1'b1;
                    overflow    <= ovf_next;
                    out_neg     <= neg_reg && !ovf_next;
                    out_frac    <= frac_next && !ovf_next;
                    dp_position <= dp_next;
                    disp_num    <= ovf_next ? {N_DIGITS{DIG_MINUS}} : disp_next;
                    state       <= IDLE;
                end
                ERR: begin
                    out_valid   <= 1'b1;
                    overflow    <= 1'b0;
                    out_neg     <= 1'b0;
                    out_frac    <= 1'b0;
                    dp_position <= '0;
                    disp_num    <= {N_DIGITS{DIG_MINUS}};
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_display_fmt.sv
// Self-checking bench for calc_display_fmt (DATA_W=25, N_DIGITS=4, FRAC_DIGITS=3)
// using directed cases plus randomized requests against a decimal-arithmetic model.
module tb_calc_display_fmt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] data;
    logic        neg;
    logic        frac;
    logic        error;
    logic        out_valid;
    logic        out_neg;
    logic        out_frac;
    logic        overflow;
    logic [3:0]  dp_position;
    logic [15:0] disp_num;

    int vectors = 0;
    int miscompares = 0;

    // {out_neg, out_frac, overflow, dp_position, disp_num}
    logic [22:0] act;
    assign act = {out_neg, out_frac, overflow, dp_position, disp_num};

    calc_display_fmt #(
        .DATA_W      (25),
        .N_DIGITS    (4),
        .FRAC_DIGITS (3),
        .BCD_DIGITS  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data        (data),
        .neg         (neg),
        .frac        (frac),
        .error       (error),
        .out_valid   (out_valid),
        .out_neg     (out_neg),
        .out_frac    (out_frac),
        .overflow    (overflow),
        .dp_position (dp_position),
        .disp_num    (disp_num)
    );

    always #5 clk = ~clk;

    logic [24:0] d_tab [6] = '{25'd5000, 25'd12500, 25'd1050, 25'd1234567, 25'd12345000, 25'd0};
    bit          n_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit          f_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [22:0] e_tab [6] = '{{3'b000, 4'b0000, 16'hAAA5},
                               {3'b110, 4'b0010, 16'hB125},
                               {3'b010, 4'b0100, 16'hA105},
                               {3'b010, 4'b0001, 16'h1234},
                               {3'b001, 4'b0000, 16'hBBBB},
                               {3'b010, 4'b0001, 16'hAAA0}};

    // Decimal model: split into integer and fractional parts, count digits,
    // strip trailing fractional zeros, truncate to the free slots.
    function automatic logic [22:0] model(input int unsigned d, input bit n, input bit f, input bit e);
        int unsigned ip, fp, f2, p, num, shown_frac;
        int il, fl, s, fs;
        logic [15:0] disp;
        logic [3:0]  dp;
        if (e) return {3'b000, 4'b0000, 16'hBBBB};
        ip = d / 1000;
        fp = d % 1000;
        il = 1;
        p  = ip;
        while (p >= 10) begin p = p / 10; il++; end
        fl = 0;
        if (fp != 0) begin
            fl = 3;
            f2 = fp;
            while (f2 % 10 == 0) begin f2 = f2 / 10; fl--; end
        end
        s = 4 - int'(n);
        if (il > s) return {3'b001, 4'b0000, 16'hBBBB};
        fs = (fl < s - il) ? fl : s - il;
        shown_frac = fp;
        for (int i = 0; i < 3 - fs; i++) shown_frac = shown_frac / 10;
        num = ip;
        for (int i = 0; i < fs; i++) num = num * 10;
        num = num + shown_frac;
        for (int j = 0; j < 4; j++) begin
            disp[4*j +: 4] = (j < il + fs) ? 4'(num % 10) : 4'd10;
            num = num / 10;
        end
        if (n) disp[15:12] = 4'd11;
        dp = (fl > 0 || f) ? 4'(1 << fs) : 4'd0;
        return {n, (fl > 0 || f), 1'b0, dp, disp};
    endfunction

    // Issue one request and return the number of edges from accept to out_valid (-1 if none).
    task automatic drive(input logic [24:0] d, input bit n, input bit f, input bit e, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        data = d; neg = n; frac = f; error = e; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; data = '0; neg = 1'b0; frac = 1'b0; error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, act} !== {1'b1, 1'b0, 23'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got ready=%b valid=%b out=%h, expected ready=1 valid=0 out=000000",
                     in_ready, out_valid, act);
        end
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 6; i++) begin
            drive(d_tab[i], n_tab[i], f_tab[i], 1'b0, lat);
            $display("txn directed data=%0d neg=%b frac=%b -> out=%h lat=%0d", d_tab[i], n_tab[i], f_tab[i], act, lat);
            vectors++;
            if (lat != 26) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d, expected 26", i, lat);
            end
            vectors++;
            if (act !== e_tab[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got %h, expected %h", i, act, e_tab[i]);
            end
            repeat (2) @(posedge clk);
            #1;
            vectors++;
            if ({out_valid, act} !== {1'b0, e_tab[i]}) begin
                miscompares++;
                $display("FAIL directed_hold[%0d]: got valid=%b out=%h, expected valid=0 out=%h",
                         i, out_valid, act, e_tab[i]);
            end
        end
    endtask

    task automatic test_error();
        int lat;
        for (int i = 0; i < 2; i++) begin
            drive(25'd1234 + 25'(i), 1'(i), 1'(i), 1'b1, lat);
            $display("txn error neg=%b -> out=%h lat=%0d", 1'(i), act, lat);
            vectors++;
            if (lat != 1) begin
                miscompares++;
                $display("FAIL error_latency[%0d]: got %0d, expected 1", i, lat);
            end
            vectors++;
            if (act !== {3'b000, 4'b0000, 16'hBBBB}) begin
                miscompares++;
                $display("FAIL error_result[%0d]: got %h, expected 00bbbb", i, act);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int busy_ready;
        busy_ready = 0;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        data = 25'd12500; neg = 1'b1; frac = 1'b0; error = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 53; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses.push_back(c);
            if (in_ready && c < 26) busy_ready++;
        end
        in_valid = 1'b0;
        $display("txn back_to_back pulses=%0d first=%0d last=%0d", pulses.size(),
                 pulses.size() > 0 ? pulses[0] : -1, pulses.size() > 0 ? pulses[pulses.size()-1] : -1);
        vectors++;
        if (pulses.size() != 2 || pulses[0] != 26 || pulses[1] != 53) begin
            miscompares++;
            $display("FAIL back_to_back_timing: got %0d pulses first=%0d, expected 2 pulses at 26 and 53",
                     pulses.size(), pulses.size() > 0 ? pulses[0] : -1);
        end
        vectors++;
        if (busy_ready != 0) begin
            miscompares++;
            $display("FAIL back_to_back_ready: got ready high in %0d busy cycles, expected 0", busy_ready);
        end
        vectors++;
        if (act !== {3'b110, 4'b0010, 16'hB125}) begin
            miscompares++;
            $display("FAIL back_to_back_result: got %h, expected %h", act, {3'b110, 4'b0010, 16'hB125});
        end
    endtask

    task automatic test_reset_mid_convert();
        int seen;
        int lat;
        logic [22:0] exp;
        seen = 0;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        data = 25'd777; neg = 1'b0; frac = 1'b0; error = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, act} !== {1'b1, 1'b0, 23'd0}) begin
            miscompares++;
            $display("FAIL mid_convert_reset: got ready=%b valid=%b out=%h, expected ready=1 valid=0 out=000000",
                     in_ready, out_valid, act);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        $display("txn reset_mid_convert stray_pulses=%0d", seen);
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL mid_convert_no_valid: got %0d out_valid pulses, expected 0", seen);
        end
        drive(25'd42005, 1'b1, 1'b0, 1'b0, lat);
        exp = model(42005, 1'b1, 1'b0, 1'b0);
        $display("txn after_reset data=42005 neg=1 -> out=%h lat=%0d", act, lat);
        vectors++;
        if (lat != 26 || act !== exp) begin
            miscompares++;
            $display("FAIL after_reset_request: got out=%h lat=%0d, expected out=%h lat=26", act, lat, exp);
        end
    endtask

    task automatic test_random();
        int unsigned d;
        bit n, f, e;
        int lat, exp_lat;
        logic [22:0] exp;
        for (int i = 0; i < 40; i++) begin
            d = $urandom % (10 ** $urandom_range(1, 8));
            if (d >= (1 << 25)) d = d % (1 << 25);
            n = 1'($urandom);
            f = 1'($urandom);
            e = ($urandom_range(0, 7) == 0);
            drive(25'(d), n, f, e, lat);
            exp = model(d, n, f, e);
            exp_lat = e ? 1 : 26;
            $display("txn random data=%0d neg=%b frac=%b err=%b -> out=%h exp=%h lat=%0d", d, n, f, e, act, exp, lat);
            vectors++;
            if (lat != exp_lat || act !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]: got out=%h lat=%0d, expected out=%h lat=%0d", i, act, lat, exp, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_error();
        test_back_to_back();
        test_reset_mid_convert();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
